// File: rtl/spi_pkg.sv
// Shared SPI definitions for the mode-0 master and slave.
// Contents: the master FSM state enum and the clock polarity/phase constants
// both ends of the link agree on. No ports.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_if.sv
// Bus bundle for spi_master: parallel start/busy/done handshake plus the
// four SPI wires.
//   start, tx_data        : request side (into the master)
//   busy, done, rx_data   : status/result side (out of the master)
//   sclk, mosi, ss_n      : SPI outputs of the master
//   miso                  : SPI input of the master
// modport master is used by spi_master; modport slave is the opposite view.
interface spi_master_if #(
  parameter int unsigned WIDTH = 8
);
  import spi_pkg::*;

  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             ss_n;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, ss_n
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, ss_n
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period phase counter for the SPI master.
//   clk, rst : system clock, synchronous active-high reset
//   en       : count while a frame is in progress
//   clr      : hold the counter at zero (idle)
//   tick     : high in the last clk cycle of each CLKDIV-long phase
module spi_clk_div #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  import spi_pkg::*;

  localparam int unsigned PW = $clog2(CLKDIV + 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == PW'(CLKDIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0). Serialises tx_data onto mosi,
// deserialises miso into rx_data, drives ss_n, handshakes via start/busy/done.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_master_if.master (start, tx_data, busy, done, rx_data,
//              sclk, mosi, miso, ss_n)
// Parameters: WIDTH (bits per frame, >= 2), CLKDIV (sclk half-period, >= 1).
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB first; default
// is MSB first. Frame timing is the same in both builds.
// All outputs come straight from flops.
module spi_master #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CLKDIV = 4
) (
  input logic           clk,
  input logic           rst,
  spi_master_if.master  bus
);
  import spi_pkg::*;

  localparam int unsigned BW = $clog2(WIDTH + 1);

  spi_state_e       state, state_d;
  logic [WIDTH-1:0] tx_sh, tx_d;
  logic [WIDTH-1:0] rx_sh, rx_d;
  logic [BW-1:0]    bit_cnt, bit_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ss_n_q, ss_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rx_q, rxo_d;
  logic             tick;

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return w[0];
  endfunction
  function automatic logic [WIDTH-1:0] tx_adv(input logic [WIDTH-1:0] w);
    return {1'b0, w[WIDTH-1:1]};
  endfunction
  function automatic logic [WIDTH-1:0] rx_in(input logic [WIDTH-1:0] w, input logic b);
    return {b, w[WIDTH-1:1]};
  endfunction
`else
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return w[WIDTH-1];
  endfunction
  function automatic logic [WIDTH-1:0] tx_adv(input logic [WIDTH-1:0] w);
    return {w[WIDTH-2:0], 1'b0};
  endfunction
  function automatic logic [WIDTH-1:0] rx_in(input logic [WIDTH-1:0] w, input logic b);
    return {w[WIDTH-2:0], b};
  endfunction
`endif

  spi_clk_div #(
    .CLKDIV(CLKDIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // Output registers are loaded with the value of the state being entered,
  // so each output changes on the same edge as the state it belongs to.
  always_comb begin
    state_d = state;
    tx_d    = tx_sh;
    rx_d    = rx_sh;
    bit_d   = bit_cnt;
    sclk_d  = SPI_CPOL;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rxo_d   = rx_q;

    unique case (state)
      IDLE: begin
        mosi_d = 1'b0;
        ss_n_d = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = LEAD;
          tx_d    = bus.tx_data;
          mosi_d  = out_bit(bus.tx_data);
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
        end
      end
      LEAD, LOW: begin
        if (tick) begin
          state_d = HIGH;
          sclk_d  = ~SPI_CPOL;
          rx_d    = rx_in(rx_sh, bus.miso);
        end
      end
      HIGH: begin
        sclk_d = ~SPI_CPOL;
        if (tick) begin
          sclk_d = SPI_CPOL;
          // The falling edge after the last bit goes straight to TRAIL so
          // that mosi keeps the last bit.
          if (bit_cnt == BW'(WIDTH - 1)) begin
            state_d = TRAIL;
          end else begin
            state_d = LOW;
            tx_d    = tx_adv(tx_sh);
            mosi_d  = out_bit(tx_adv(tx_sh));
            bit_d   = bit_cnt + BW'(1);
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d = IDLE;
          mosi_d  = 1'b0;
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rxo_d   = rx_sh;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      sclk_q  <= SPI_CPOL;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
    end else begin
      state   <= state_d;
      tx_sh   <= tx_d;
      rx_sh   <= rx_d;
      bit_cnt <= bit_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rx_q    <= rxo_d;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss_n    = ss_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: WIDTH=8/CLKDIV=2 and WIDTH=16/CLKDIV=1
// instances. Bit order of the model follows SPI_MASTER_LSB_FIRST_EN.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_if #(.WIDTH(8))  bus8();
  spi_master_if #(.WIDTH(16)) bus16();

  spi_master #(.WIDTH(8), .CLKDIV(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  spi_master #(.WIDTH(16), .CLKDIV(1)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   miso_mode = 0;   // 0 loopback, 1 tied to miso_drv, 2 random per cycle
  logic miso_drv = 1'b0;

  assign bus8.miso  = (miso_mode == 0) ? bus8.mosi : miso_drv;
  assign bus16.miso = bus16.mosi;

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  // Word position of the i-th bit on the wire.
  function automatic int pos(input int i, input int w);
    return LSB_FIRST ? i : (w - 1 - i);
  endfunction

  function automatic logic [7:0] wire_order8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[pos(i, 8)];
    return r;
  endfunction

  function automatic logic [7:0] word_from_wire8(input logic [7:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[pos(i, 8)] = s[i];
    return r;
  endfunction

  // Observes one 8-bit frame from acceptance to done (or 200-cycle timeout).
  // Entered and left at posedge+1. hold: 0 drop start, 1 keep start high,
  // 2 toggle start randomly while busy.
  task automatic run8(input logic [7:0] tx, input logic [7:0] tx_after, input int hold,
                      output int done_cyc, output logic [7:0] rx, output int n_rise,
                      output logic [7:0] mosi_seq, output logic [7:0] miso_seq,
                      output int ss_bad, output int mosi_ones, output int busy1);
    logic prev_sclk, prev_miso;
    done_cyc = -1; rx = '0; n_rise = 0; mosi_seq = '0; miso_seq = '0;
    ss_bad = 0; mosi_ones = 0; busy1 = 0;
    bus8.tx_data = tx;
    bus8.start   = 1'b1;
    prev_sclk = bus8.sclk;
    prev_miso = (miso_mode == 0) ? bus8.mosi : miso_drv;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        busy1 = (bus8.busy === 1'b1 && bus8.ss_n === 1'b0) ? 1 : 0;
        bus8.tx_data = tx_after;
        if (hold == 0) bus8.start = 1'b0;
      end else if (hold == 2) begin
        bus8.start = 1'($urandom_range(0, 1));
      end
      if (bus8.sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (n_rise < 8) begin
          mosi_seq[n_rise] = bus8.mosi;
          miso_seq[n_rise] = prev_miso;
        end
        n_rise++;
        if (bus8.ss_n !== 1'b0) ss_bad++;
      end
      if (bus8.mosi === 1'b1) mosi_ones++;
      if (bus8.done === 1'b1) begin
        done_cyc = c;
        rx = bus8.rx_data;
        break;
      end
      prev_sclk = bus8.sclk;
      if (miso_mode == 2) miso_drv = 1'($urandom_range(0, 1));
      prev_miso = (miso_mode == 0) ? bus8.mosi : miso_drv;
    end
    if (hold == 2) bus8.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0;  bus8.tx_data = '0;
    bus16.start = 1'b0; bus16.tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus8.ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n got=%b exp=1", bus8.ss_n); end
    n_tests++; if (bus8.sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b exp=0", bus8.sclk); end
    n_tests++; if (bus8.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", bus8.mosi); end
    n_tests++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got=%b%b exp=00", bus8.busy, bus8.done); end
    n_tests++; if (bus8.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", bus8.rx_data); end
    n_tests++; if (bus16.ss_n !== 1'b1 || bus16.busy !== 1'b0) begin n_fail++; $display("FAIL reset16 got ss_n=%b busy=%b exp 1 0", bus16.ss_n, bus16.busy); end
    rst = 1'b0;
  endtask

  task automatic test_loopback_a5();
    int dc, nr, sb, mo, b1; logic [7:0] rx, ms, is;
    miso_mode = 0;
    run8(8'hA5, 8'hA5, 0, dc, rx, nr, ms, is, sb, mo, b1);
    n_tests++; if (b1 != 1) begin n_fail++; $display("FAIL a5_cycle1 got busy/ss_n ok=%0d exp=1", b1); end
    n_tests++; if (dc != 35) begin n_fail++; $display("FAIL a5_done_cycle got=%0d exp=35", dc); end
    n_tests++; if (rx !== 8'hA5) begin n_fail++; $display("FAIL a5_rx got=%h exp=a5", rx); end
    n_tests++; if (ms !== wire_order8(8'hA5)) begin n_fail++; $display("FAIL a5_mosi_seq got=%b exp=%b", ms, wire_order8(8'hA5)); end
    n_tests++; if (nr != 8 || sb != 0) begin n_fail++; $display("FAIL a5_sclk_edges got=%0d bad_ss=%0d exp=8 0", nr, sb); end
    n_tests++; if (bus8.busy !== 1'b0 || bus8.ss_n !== 1'b1) begin n_fail++; $display("FAIL a5_done_idle got busy=%b ss_n=%b", bus8.busy, bus8.ss_n); end
    @(posedge clk); #1;
    n_tests++; if (bus8.done !== 1'b0 || bus8.rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_after_done got done=%b rx=%h exp 0 a5", bus8.done, bus8.rx_data); end
  endtask

  task automatic test_tied_miso();
    int dc, nr, sb, mo, b1; logic [7:0] rx, ms, is;
    miso_mode = 1; miso_drv = 1'b1;
    run8(8'h00, 8'h00, 0, dc, rx, nr, ms, is, sb, mo, b1);
    n_tests++; if (rx !== 8'hFF || dc != 35) begin n_fail++; $display("FAIL tied1_rx got=%h cyc=%0d exp=ff 35", rx, dc); end
    n_tests++; if (mo != 0) begin n_fail++; $display("FAIL tied1_mosi_low got=%0d high cycles exp=0", mo); end
    miso_drv = 1'b0;
    run8(8'h00, 8'h00, 0, dc, rx, nr, ms, is, sb, mo, b1);
    n_tests++; if (rx !== 8'h00 || dc != 35) begin n_fail++; $display("FAIL tied0_rx got=%h cyc=%0d exp=00 35", rx, dc); end
    miso_mode = 0;
  endtask

  task automatic test_random();
    int dc, nr, sb, mo, b1; logic [7:0] rx, ms, is, tx;
    miso_mode = 2;
    for (int k = 0; k < 6; k++) begin
      tx = 8'($urandom);
      run8(tx, 8'($urandom), 0, dc, rx, nr, ms, is, sb, mo, b1);
      n_tests++; if (ms !== wire_order8(tx)) begin n_fail++; $display("FAIL rand_mosi[%0d] got=%b exp=%b", k, ms, wire_order8(tx)); end
      n_tests++; if (rx !== word_from_wire8(is) || dc != 35) begin n_fail++; $display("FAIL rand_rx[%0d] got=%h cyc=%0d exp=%h 35", k, rx, dc, word_from_wire8(is)); end
    end
    miso_mode = 0;
  endtask

  task automatic test_start_ignored();
    int dc, nr, sb, mo, b1; logic [7:0] rx, ms, is, tx;
    miso_mode = 0;
    for (int k = 0; k < 3; k++) begin
      tx = 8'($urandom);
      run8(tx, ~tx, 2, dc, rx, nr, ms, is, sb, mo, b1);
      n_tests++; if (rx !== tx || dc != 35 || nr != 8) begin n_fail++; $display("FAIL busy_start[%0d] got rx=%h cyc=%0d edges=%0d exp=%h 35 8", k, rx, dc, nr, tx); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int dc, nr, sb, mo, b1; logic [7:0] rx, ms, is;
    miso_mode = 0;
    run8(8'h3C, 8'hC3, 1, dc, rx, nr, ms, is, sb, mo, b1);
    n_tests++; if (rx !== 8'h3C || dc != 35) begin n_fail++; $display("FAIL b2b_first got rx=%h cyc=%0d exp=3c 35", rx, dc); end
    n_tests++; if (bus8.ss_n !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_ss_n got=%b exp=1", bus8.ss_n); end
    run8(8'hC3, 8'hC3, 0, dc, rx, nr, ms, is, sb, mo, b1);
    n_tests++; if (b1 != 1) begin n_fail++; $display("FAIL b2b_second_accept got=%0d exp=1", b1); end
    n_tests++; if (rx !== 8'hC3 || dc != 35) begin n_fail++; $display("FAIL b2b_second got rx=%h cyc=%0d exp=c3 35", rx, dc); end
  endtask

  task automatic test_abort();
    int dc, nr, sb, mo, b1, dones; logic [7:0] rx, ms, is;
    miso_mode = 0;
    bus8.tx_data = 8'h5A; bus8.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus8.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (bus8.ss_n !== 1'b1 || bus8.sclk !== 1'b0 || bus8.mosi !== 1'b0) begin n_fail++; $display("FAIL abort_lines got ss_n=%b sclk=%b mosi=%b exp 1 0 0", bus8.ss_n, bus8.sclk, bus8.mosi); end
    n_tests++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.rx_data !== 8'h00) begin n_fail++; $display("FAIL abort_status got busy=%b done=%b rx=%h exp 0 0 00", bus8.busy, bus8.done, bus8.rx_data); end
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus8.done === 1'b1 || bus8.ss_n !== 1'b1) dones++;
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d active cycles exp=0", dones); end
    run8(8'h96, 8'h96, 0, dc, rx, nr, ms, is, sb, mo, b1);
    n_tests++; if (rx !== 8'h96 || dc != 35) begin n_fail++; $display("FAIL abort_recover got rx=%h cyc=%0d exp=96 35", rx, dc); end
  endtask

  task automatic test_clkdiv1();
    int dc, toggles; logic [15:0] rx; logic prev;
    dc = -1; toggles = 0; rx = '0;
    bus16.tx_data = 16'h8001; bus16.start = 1'b1;
    prev = bus16.sclk;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus16.start = 1'b0;
      if (c >= 2 && c <= 33 && bus16.sclk !== prev) toggles++;
      prev = bus16.sclk;
      if (bus16.done === 1'b1) begin dc = c; rx = bus16.rx_data; break; end
    end
    n_tests++; if (dc != 34) begin n_fail++; $display("FAIL div1_done_cycle got=%0d exp=34", dc); end
    n_tests++; if (rx !== 16'h8001) begin n_fail++; $display("FAIL div1_rx got=%h exp=8001", rx); end
    n_tests++; if (toggles != 32) begin n_fail++; $display("FAIL div1_sclk_toggles got=%0d exp=32", toggles); end
  endtask

  task automatic test_bit_order();
    int dc, nr, sb, mo, b1; logic [7:0] rx, ms, is;
    miso_mode = 0;
    run8(8'h01, 8'h01, 0, dc, rx, nr, ms, is, sb, mo, b1);
    n_tests++; if (ms[0] !== (LSB_FIRST ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL order_first_bit got=%b exp=%b", ms[0], LSB_FIRST); end
    n_tests++; if (ms !== wire_order8(8'h01)) begin n_fail++; $display("FAIL order_mosi_seq got=%b exp=%b", ms, wire_order8(8'h01)); end
    n_tests++; if (rx !== 8'h01) begin n_fail++; $display("FAIL order_rx got=%h exp=01", rx); end
  endtask

  initial begin
    test_reset();
    test_loopback_a5();
    test_tied_miso();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    test_clkdiv1();
    test_bit_order();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master (CPOL=0, CPHA=0) that serialises a parallel word onto MOSI and deserialises MISO, with frame-select generation and a start/busy/done handshake. It is the initiating end of the SPI link served by the team's mode-0 SPI slave. It sits in the system clock domain and drives sclk, mosi and ss_n as registered outputs derived from clk.

## Interface
Parameters:
- WIDTH, 8: bits per frame; must be ≥ 2.
- CLKDIV, 4: sclk half-period in clk cycles; must be ≥ 1. sclk frequency = clk / (2·CLKDIV).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a frame; sampled only in IDLE.
- tx_data  in  WIDTH  word to transmit; captured in the cycle start is accepted.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the frame ends and rx_data is valid.
- rx_data  out  WIDTH  last received word; held until the next done.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- ss_n  out  1  active-low slave select.

## Operation
- States: IDLE, LEAD, HIGH, LOW, TRAIL.
- IDLE: ss_n=1, sclk=0, mosi=0, busy=0. On start=1, latch tx_data into tx shift register, go to LEAD.
- LEAD: ss_n=0, mosi = first bit, sclk=0, hold CLKDIV cycles, then go to HIGH.
- HIGH: sclk=1 for CLKDIV cycles. At the clk edge where sclk goes 0→1, shift the sampled miso into the rx shift register.
- LOW: sclk=0 for CLKDIV cycles. At the edge where sclk goes 1→0, if bits remain, advance mosi to the next bit and return to HIGH after CLKDIV cycles. After the WIDTH-th falling edge, go to TRAIL; mosi holds the last bit.
- TRAIL: sclk=0, ss_n=0 for CLKDIV cycles. Then go to IDLE: ss_n=1, rx_data ← rx shift register, done=1 for one cycle.
- Bit order: MSB first by default. The first miso bit received lands in rx_data[WIDTH-1].
- Counters:
  - Phase counter: $clog2(CLKDIV+1) bits.
  - Bit counter: $clog2(WIDTH+1) bits.
  - Both wrap only under state control, never free-running.
- start is ignored while busy=1; no queueing. tx_data changes after acceptance do not affect the frame.
- Reset:
  - rst asserted mid-frame aborts the frame. Next cycle: IDLE, ss_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0.
  - No done pulse is issued for an aborted frame.

## Timing
- Cycle 0 = start accepted. ss_n falls and busy rises at cycle 1.
- Rising edge of bit i (i=0..WIDTH-1) occurs at cycle 1+CLKDIV+2·i·CLKDIV.
- Last falling edge: cycle 1+2·WIDTH·CLKDIV.
- ss_n rises, busy falls and done pulses at cycle 1+(2·WIDTH+1)·CLKDIV.
- done and busy=0 coincide. A start in the done cycle is accepted, so ss_n is high for at least 1 cycle between frames.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SPI_MASTER_LSB_FIRST_EN defined: LSB transmitted first; the first miso bit lands in rx_data[0].
- Undefined (default): MSB first, as described above.
- Timing is identical in both builds.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE, LEAD, HIGH, LOW, TRAIL);
  - constants SPI_CPOL=0 and SPI_CPHA=0, shared with the slave.
- Sub-module spi_clk_div: phase counter producing the half-period tick, with enable/clear from the FSM. Everything else is in spi_master.

## Test plan
- WIDTH=8, CLKDIV=2, tx_data=0xA5, miso looped from mosi:
  - done at cycle 35, rx_data=0xA5;
  - mosi sequence 1,0,1,0,0,1,0,1;
  - 8 sclk rising edges, all with ss_n=0.
- miso tied 1, tx_data=0x00 → rx_data=0xFF, mosi low throughout. Then miso tied 0 → rx_data=0x00.
- start held high continuously across two frames (0x3C then 0xC3):
  - second frame accepted in the done cycle;
  - ss_n high exactly 1 cycle between frames;
  - start pulses during busy have no effect.
- rst asserted at cycle 10 of a frame:
  - next cycle ss_n=1, sclk=0, busy=0, rx_data=0;
  - no done;
  - a new frame afterwards completes correctly.
- CLKDIV=1, WIDTH=16, tx_data=0x8001, loopback → done at cycle 34, rx_data=0x8001, sclk toggles every cycle.
- SPI_MASTER_LSB_FIRST_EN defined, tx_data=0x01 → first mosi bit 1, remaining 0. Loopback rx_data=0x01.
